// File: rtl/comparator_serial.sv
`default_nettype none
// ============================================================================
// Module      : comparator_serial
// Description : Sequential magnitude comparator. Two WIDTH-bit operands are
//               compared DIGIT bits per clock, most-significant digit first,
//               in unsigned or two's-complement signed mode. A start/done
//               handshake frames each operation. The eq/lt/gt flags are
//               registered and held until the next done pulse or reset.
//               Optional build macro COMPARATOR_SERIAL_EARLY_EXIT_EN:
//                 defined   -> finish on the first differing digit
//                              (latency 2..N+1 cycles)
//                 undefined -> always walk all N digits (latency N+1 cycles)
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic             A_eq_B,
    output logic             A_lt_B,
    output logic             A_gt_B
);

    // Number of digits per operand.
    localparam int N = WIDTH / DIGIT;
    localparam int c_IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(N - 1);
    localparam logic [c_IDXW-1:0] c_ZERO_IDX = '0;

    // Flipping the sign bit of both operands maps two's-complement ordering
    // onto unsigned ordering, so one unsigned digit comparator serves both.
    localparam logic [WIDTH-1:0] c_SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_CMP  = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;

    // Latched operands; shifted left one digit per cycle so the digit under
    // test always sits in the top DIGIT bits.
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [c_IDXW-1:0] r_idx;

    logic              r_done;
    logic              r_eq;
    logic              r_lt;
    logic              r_gt;

    logic [DIGIT-1:0]  w_dig_a;
    logic [DIGIT-1:0]  w_dig_b;
    logic              w_dig_lt;
    logic              w_dig_gt;
    logic              w_dig_ne;
    logic              w_last;
    logic              w_fin;
    logic              w_accept;
    logic              w_res_eq;
    logic              w_res_lt;
    logic              w_res_gt;

`ifndef COMPARATOR_SERIAL_EARLY_EXIT_EN
    // First differing digit seen so far, kept while the remaining digits
    // are walked for constant latency.
    logic              r_found;
    logic              r_found_lt;
`endif

    // Current digit pair and its unsigned ordering.
    always_comb begin
        w_dig_a  = r_a[WIDTH-1 -: DIGIT];
        w_dig_b  = r_b[WIDTH-1 -: DIGIT];
        w_dig_lt = (w_dig_a < w_dig_b);
        w_dig_gt = (w_dig_a > w_dig_b);
        w_dig_ne = (w_dig_a != w_dig_b);
    end

    // Decide whether the current CMP cycle is the final one.
    always_comb begin
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
        w_last = w_dig_ne || (r_idx == c_ZERO_IDX);
`else
        w_last = (r_idx == c_ZERO_IDX);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_nxt = c_S_CMP;
                end
            end
            c_S_CMP: begin
                if (w_last) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Output decode: busy, operation accept/finish strobes and result flags.
    always_comb begin
        busy     = (r_state == c_S_CMP);
        w_accept = (r_state == c_S_IDLE) && start;
        w_fin    = (r_state == c_S_CMP) && w_last;
        w_res_eq = !w_dig_ne;
        w_res_lt = w_dig_lt;
        w_res_gt = w_dig_gt;
`ifndef COMPARATOR_SERIAL_EARLY_EXIT_EN
        // An earlier (more significant) difference outranks the current digit.
        if (r_found) begin
            w_res_eq = 1'b0;
            w_res_lt = r_found_lt;
            w_res_gt = !r_found_lt;
        end
`endif
    end

    // Operand latch, digit walk, done pulse and held result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_eq   <= 1'b0;
            r_lt   <= 1'b0;
            r_gt   <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_fin) begin
                r_eq <= w_res_eq;
                r_lt <= w_res_lt;
                r_gt <= w_res_gt;
            end
            if (w_accept) begin
                r_a   <= is_signed ? (inA ^ c_SIGN_MASK) : inA;
                r_b   <= is_signed ? (inB ^ c_SIGN_MASK) : inB;
                r_idx <= c_LAST_IDX;
            end else if (busy) begin
                r_a   <= r_a << DIGIT;
                r_b   <= r_b << DIGIT;
                r_idx <= r_idx - 1'b1;
            end
        end
    end

`ifndef COMPARATOR_SERIAL_EARLY_EXIT_EN
    // Remember the most significant differing digit of this operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_found    <= 1'b0;
            r_found_lt <= 1'b0;
        end else if (w_accept) begin
            r_found    <= 1'b0;
            r_found_lt <= 1'b0;
        end else if (busy && w_dig_ne && !r_found) begin
            r_found    <= 1'b1;
            r_found_lt <= w_dig_lt;
        end
    end
`endif

    assign done   = r_done;
    assign A_eq_B = r_eq;
    assign A_lt_B = r_lt;
    assign A_gt_B = r_gt;

endmodule
`default_nettype wire
